pwm_generator: RTL and testbench



---
 rtl/pwm_generator.sv | 55 +++++
 tb/tb_pwm_generator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - switch-driven 16-step PWM source with synchronised inputs
// Duty is sampled only at the period boundary, so every period is glitch-free.
module pwm_generator #(
    parameter int CLK_DIV = 8
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [3:0] SW,
    output logic       Pulse
);

    localparam logic [15:0] PRE_MAX = 16'(CLK_DIV - 1);

    logic [3:0]  sw_meta_q, sw_meta_d;
    logic [3:0]  sw_s_q, sw_s_d;
    logic [15:0] pre_q, pre_d;
    logic [3:0]  step_q, step_d;
    logic [3:0]  duty_q, duty_d;
    logic        pulse_q, pulse_d;
    logic        tick;
    logic        boundary;

    always_comb begin
        sw_meta_d = SW;
        sw_s_d    = sw_meta_q;
        tick      = (pre_q == PRE_MAX);
        boundary  = tick && (step_q == 4'd15);
        pre_d     = tick ? 16'd0 : pre_q + 16'd1;
        step_d    = tick ? step_q + 4'd1 : step_q;
        // The shadow load uses the already-synchronised value, never the raw pins.
        duty_d    = boundary ? sw_s_q : duty_q;
        pulse_d   = (step_q < duty_q);
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            sw_meta_q <= 4'd0;
            sw_s_q    <= 4'd0;
            pre_q     <= 16'd0;
            step_q    <= 4'd0;
            duty_q    <= 4'd0;
            pulse_q   <= 1'b0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_s_q    <= sw_s_d;
            pre_q     <= pre_d;
            step_q    <= step_d;
            duty_q    <= duty_d;
            pulse_q   <= pulse_d;
        end
    end

    assign Pulse = pulse_q;

endmodule

// File: tb/tb_pwm_generator.sv
// tb/tb_pwm_generator.sv - directed bench for pwm_generator at CLK_DIV 8 and 1
module tb_pwm_generator;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] sw1;
    logic       pulse;
    logic       pulse1;
    int         errors = 0;
    int         checks = 0;

    always #10 sysclk = ~sysclk;

    pwm_generator #(.CLK_DIV(8)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .SW(sw), .Pulse(pulse)
    );

    pwm_generator #(.CLK_DIV(1)) dut1 (
        .sysclk(sysclk), .rst_n(rst_n), .SW(sw1), .Pulse(pulse1)
    );

    task automatic wait_rise(input bit sel, input string name);
        bit prev, cur, done;
        int n;
        prev = sel ? pulse1 : pulse;
        done = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            @(negedge sysclk);
            cur = sel ? pulse1 : pulse;
            n++;
            if (cur && !prev) done = 1'b1;
            prev = cur;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: no rising edge within %0d cycles (required one)", name, n);
        end
    endtask

    // Entered on the first high sample; returns on the first high sample of the next period.
    task automatic measure(input bit sel, input int change_at, input logic [3:0] new_sw,
                           output int high, output int per);
        bit cur, low_seen, done;
        high = 1;
        per = 1;
        low_seen = 1'b0;
        done = 1'b0;
        while (!done && per < 400) begin
            if (per == change_at) sw = new_sw;
            @(negedge sysclk);
            cur = sel ? pulse1 : pulse;
            if (!cur) low_seen = 1'b1;
            else if (low_seen) done = 1'b1;
            if (!done) begin
                per++;
                if (cur && !low_seen) high++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL measure: period did not end within %0d cycles", per);
        end
    endtask

    task automatic test_reset();
        int highs;
        rst_n = 1'b0;
        sw = 4'b0000;
        sw1 = 4'b0000;
        repeat (5) @(negedge sysclk);
        checks++;
        if (pulse !== 1'b0 || pulse1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pulse=%b pulse1=%b required 0 0", pulse, pulse1);
        end
        rst_n = 1'b1;
        highs = 0;
        repeat (1280) begin
            @(negedge sysclk);
            if (pulse !== 1'b0 || pulse1 !== 1'b0) highs++;
        end
        checks++;
        if (highs !== 0) begin
            errors++;
            $display("FAIL reset_sw0: %0d high samples over 10 periods, required 0", highs);
        end
    endtask

    task automatic test_first_duty();
        int n;
        rst_n = 1'b0;
        sw = 4'b0001;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        n = 0;
        while (pulse !== 1'b1 && n < 400) begin
            @(negedge sysclk);
            n++;
        end
        checks++;
        if (n !== 129) begin
            errors++;
            $display("FAIL first_rise: first high after %0d edges, required 129", n);
        end
    endtask

    task automatic test_duty_steps();
        int high, per;
        measure(1'b0, -1, 4'd0, high, per);
        checks++;
        if (high !== 8 || per !== 128) begin
            errors++;
            $display("FAIL duty1: high=%0d period=%0d required 8 128", high, per);
        end
        sw = 4'b1001;
        measure(1'b0, -1, 4'd0, high, per);
        checks++;
        if (high !== 8 || per !== 128) begin
            errors++;
            $display("FAIL boundary_hold: high=%0d period=%0d required 8 128", high, per);
        end
        measure(1'b0, -1, 4'd0, high, per);
        checks++;
        if (high !== 72 || per !== 128) begin
            errors++;
            $display("FAIL duty9: high=%0d period=%0d required 72 128", high, per);
        end
        sw = 4'b1101;
        measure(1'b0, -1, 4'd0, high, per);
        measure(1'b0, -1, 4'd0, high, per);
        checks++;
        if (high !== 104 || per !== 128) begin
            errors++;
            $display("FAIL duty13: high=%0d period=%0d required 104 128", high, per);
        end
        sw = 4'b1111;
        measure(1'b0, -1, 4'd0, high, per);
        measure(1'b0, -1, 4'd0, high, per);
        checks++;
        if (high !== 120 || per !== 128) begin
            errors++;
            $display("FAIL duty15: high=%0d period=%0d required 120 128", high, per);
        end
    endtask

    task automatic test_mid_period();
        int high, per;
        sw = 4'b0001;
        measure(1'b0, -1, 4'd0, high, per);
        measure(1'b0, 26, 4'b1111, high, per);
        checks++;
        if (high !== 8 || per !== 128) begin
            errors++;
            $display("FAIL mid_current: high=%0d period=%0d required 8 128", high, per);
        end
        measure(1'b0, -1, 4'd0, high, per);
        checks++;
        if (high !== 120 || per !== 128) begin
            errors++;
            $display("FAIL mid_next: high=%0d period=%0d required 120 128", high, per);
        end
    endtask

    task automatic test_reset_mid();
        int n, high, per;
        repeat (10) @(negedge sysclk);
        checks++;
        if (pulse !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_high: pulse=%b required 1", pulse);
        end
        rst_n = 1'b0;
        @(negedge sysclk);
        checks++;
        if (pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_low: pulse=%b required 0", pulse);
        end
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        n = 0;
        while (pulse !== 1'b1 && n < 400) begin
            @(negedge sysclk);
            n++;
        end
        checks++;
        if (n !== 129) begin
            errors++;
            $display("FAIL reset_low_period: first high after %0d edges, required 129", n);
        end
        measure(1'b0, -1, 4'd0, high, per);
        checks++;
        if (high !== 120 || per !== 128) begin
            errors++;
            $display("FAIL reset_resume: high=%0d period=%0d required 120 128", high, per);
        end
    endtask

    task automatic test_clk_div1();
        int high, per;
        sw1 = 4'b0101;
        repeat (40) @(negedge sysclk);
        wait_rise(1'b1, "div1_rise");
        measure(1'b1, -1, 4'd0, high, per);
        checks++;
        if (high !== 5 || per !== 16) begin
            errors++;
            $display("FAIL div1_duty5: high=%0d period=%0d required 5 16", high, per);
        end
        measure(1'b1, -1, 4'd0, high, per);
        checks++;
        if (high !== 5 || per !== 16) begin
            errors++;
            $display("FAIL div1_repeat: high=%0d period=%0d required 5 16", high, per);
        end
    endtask

    initial begin
        test_reset();
        test_first_duty();
        test_duty_steps();
        test_mid_period();
        test_reset_mid();
        test_clk_div1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
